result_writeback_packer: RTL and testbench
==========================================

// Module: result_writeback_packer
// PURPOSE
//  Producer end of the result-memory write interface that control_unit consumes (result_mem_we_5 / result_mem_counter_5 / read_again).
//  Accepts one solver element per handshake and packs no_of_units elements into one memory row.
//  Zero-pads each vector to total elements, then emits one write pulse, row address and row data per row.
//  Requests the next operand row (read_again) after each non-final row and pulses finish after the last row.
// PARAMETERS
//  no_of_units                      8   elements (lanes) per memory row
//  element_width                    32  bits per element
//  number_of_equations_per_cluster  19  real elements per vector (N)
//  additional   no_of_units-(N%no_of_units)  pad count; equals no_of_units when N%no_of_units==0 (full extra zero row)
//  total                            N+additional  padded vector length (24 by default)
//  ROWS                             total/no_of_units  rows per vector (3 by default)
// PORTS
//  clk                clk  in   1   single clock, all logic on posedge
//  reset              in   1        synchronous, active-low (0 = reset)
//  start              in   1        pulse; begins a vector pass (honoured in IDLE only)
//  elem_valid         in   1        elem_data valid this cycle
//  elem_ready         out  1        block accepts elem_data this cycle
//  elem_data          in   element_width  solver element
//  result_mem_we      out  1        1-cycle row write strobe
//  result_mem_counter out  32       row address of current write, 0..ROWS-1
//  result_mem_data    out  no_of_units*element_width  packed row; lane k at [k*element_width +: element_width]
//  read_again         out  1        1-cycle request for next operand row
//  busy               out  1        high in every state except IDLE
//  finish             out  1        1-cycle pulse, vector pass complete
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; every output, lane register and counter cleared to 0. Overrides everything, including mid-pass.
//  Element k (0-based) goes to lane k%no_of_units of row k/no_of_units.
//  Counters: elem_count 0..N; lane_idx 0..no_of_units-1; row_count 0..ROWS-1.
//  FSM:
//  IDLE: elem_ready=0. start=1 -> FILL; clear elem_count, lane_idx, row_count.
//  FILL: elem_ready=1. On valid&&ready: lane[lane_idx]<=elem_data; elem_count++ and lane_idx++.
//   - lane_idx==no_of_units-1 -> WRITE.
//   - Otherwise, last real element (elem_count==N-1) -> PAD.
//   - No valid: stay in FILL, hold all state.
//  PAD: elem_ready=0; exactly 1 cycle; lanes lane_idx..no_of_units-1 <= 0; -> WRITE.
//  WRITE: exactly 1 cycle; elem_ready=0.
//   - result_mem_we=1; result_mem_counter=row_count; result_mem_data=packed lanes.
//   - read_again=1 iff row_count<ROWS-1; row_count++; lane_idx<=0.
//   - Last row -> DONE. Else elem_count==N (all-zero row remains) -> PAD. Else -> FILL.
//  DONE: finish=1 for 1 cycle; -> IDLE.
//  Latency:
//   - Row-completing element accepted at edge t -> result_mem_we high during cycle t+1.
//   - Short final row: PAD in t+1, WRITE in t+2.
//   - finish high the cycle after the last WRITE.
//  Outputs:
//   - result_mem_we, read_again and finish are registered single-cycle pulses, never high in consecutive cycles.
//   - result_mem_data/result_mem_counter hold last written values between writes.
//  Boundaries:
//   - Element offered during PAD/WRITE/DONE is not taken (ready=0); source holds it.
//   - start outside IDLE is ignored.
//   - elem_valid in IDLE is ignored.
//   - Elements beyond N are never requested (ready=0 after element N-1).
//   - Counters never exceed their bounds; no wrap within a pass.
// TESTING
//  T1 defaults: start, feed 1..19 back-to-back.
//   - Writes at addr 0,1,2; row0 lanes=1..8, row1=9..16.
//   - row2 lanes0-2=17,18,19, lanes3-7=0.
//   - read_again with rows 0,1 only; finish 1 cycle after addr-2 write.
//  T2 throttled source: elem_valid 1,0,1,0 pattern plus element held across a WRITE cycle.
//   - Row data identical to T1; elem_ready=0 in every WRITE/PAD cycle; no element lost or duplicated.
//  T3 latency: 8th element accepted at edge t -> we=1 in t+1 only, counter=0.
//   - 19th element at edge u -> PAD in u+1, we in u+2, finish in u+3.
//  T4 N=16: feed 1..16.
//   - Writes addr0=1..8, addr1=9..16, addr2 all zero via PAD.
//   - read_again on addr 0,1; 3 writes total.
//  T5 reset mid-pass: reset=0 for 1 cycle after 10 elements.
//   - Next cycle all outputs 0, busy=0.
//   - Fresh start+19 elements reproduces T1 exactly from addr 0.
//  T6 start while busy: pulse start during FILL and during WRITE.
//   - No effect; pass completes as T1 with a single finish pulse.

Source files
------------

// File: rtl/result_writeback_packer.sv
// ---------------------------------------------------------------------------
// result_writeback_packer
//
// Purpose:
//   Producer side of the result-memory write path. Solver elements arrive one
//   per valid/ready handshake and are packed, no_of_units at a time, into one
//   memory row. Each vector of number_of_equations_per_cluster elements is
//   zero-padded up to a whole number of rows. One write strobe, row address
//   and row image is produced per row. After every non-final row the block
//   asks for the next operand row (read_again). After the last row it pulses
//   finish.
//
// Ports:
//   clk                - single clock, all state on the rising edge
//   reset              - synchronous, active-low (0 = reset)
//   start              - begins a vector pass; only honoured while idle
//   elem_valid         - elem_data carries a valid element this cycle
//   elem_ready         - block takes elem_data this cycle
//   elem_data          - one solver element
//   result_mem_we      - one-cycle row write strobe
//   result_mem_counter - row address of the current write (0..ROWS-1)
//   result_mem_data    - packed row, lane k at [k*element_width +: element_width]
//   read_again         - one-cycle request for the next operand row
//   busy               - high whenever a pass is in progress
//   finish             - one-cycle pulse when the pass is complete
// ---------------------------------------------------------------------------
module result_writeback_packer #(
  parameter int no_of_units                     = 8,
  parameter int element_width                   = 32,
  parameter int number_of_equations_per_cluster = 19
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 elem_valid,
  output logic                                 elem_ready,
  input  logic [element_width-1:0]             elem_data,
  output logic                                 result_mem_we,
  output logic [31:0]                          result_mem_counter,
  output logic [no_of_units*element_width-1:0] result_mem_data,
  output logic                                 read_again,
  output logic                                 busy,
  output logic                                 finish
);

  localparam int N          = number_of_equations_per_cluster;
  // A vector whose length is already a multiple of the row width still gets
  // a full extra zero row; the consumer relies on that fixed row count.
  localparam int ADDITIONAL = no_of_units - (N % no_of_units);
  localparam int TOTAL      = N + ADDITIONAL;
  localparam int ROWS       = TOTAL / no_of_units;
  localparam int DW         = no_of_units * element_width;

  localparam int CW = $clog2(N + 1);
  localparam int LW = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] LAST_ELEM = CW'(N - 1);
  localparam logic [CW-1:0] ALL_ELEMS = CW'(N);
  localparam logic [LW-1:0] LAST_LANE = LW'(no_of_units - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            elem_count_q, elem_count_d;
  logic [LW-1:0]            lane_idx_q, lane_idx_d;
  logic [RW-1:0]            row_count_q, row_count_d;
  logic [element_width-1:0] lanes_q [no_of_units];
  logic [element_width-1:0] lanes_d [no_of_units];

  logic          we_q, we_d;
  logic [31:0]   counter_q, counter_d;
  logic [DW-1:0] data_q, data_d;
  logic          read_again_q, read_again_d;
  logic          finish_q, finish_d;

  logic [DW-1:0] lanes_packed;

  assign elem_ready         = (state_q == S_FILL);
  assign busy               = (state_q != S_IDLE);
  assign result_mem_we      = we_q;
  assign result_mem_counter = counter_q;
  assign result_mem_data    = data_q;
  assign read_again         = read_again_q;
  assign finish             = finish_q;

  // Next-state logic. This block also covers the lane registers and the
  // element, lane and row counters.
  always_comb begin
    state_d      = state_q;
    elem_count_d = elem_count_q;
    lane_idx_d   = lane_idx_q;
    row_count_d  = row_count_q;
    for (int k = 0; k < no_of_units; k++) begin
      lanes_d[k] = lanes_q[k];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FILL;
          elem_count_d = '0;
          lane_idx_d   = '0;
          row_count_d  = '0;
        end
      end

      S_FILL: begin
        if (elem_valid) begin
          lanes_d[lane_idx_q] = elem_data;
          elem_count_d        = elem_count_q + CW'(1);
          // A full row takes priority over "last element". When N is a
          // multiple of the row width, the all-zero row is reached via PAD
          // after this write instead.
          if (lane_idx_q == LAST_LANE) begin
            lane_idx_d = '0;
            state_d    = S_WRITE;
          end else begin
            lane_idx_d = lane_idx_q + LW'(1);
            if (elem_count_q == LAST_ELEM) begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        // lane_idx points at the first lane not filled by a real element.
        for (int k = 0; k < no_of_units; k++) begin
          if (k >= int'(lane_idx_q)) begin
            lanes_d[k] = '0;
          end
        end
        state_d = S_WRITE;
      end

      S_WRITE: begin
        lane_idx_d = '0;
        if (row_count_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_count_d = row_count_q + RW'(1);
          state_d     = (elem_count_q == ALL_ELEMS) ? S_PAD : S_FILL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pack the lane values that will be present after this edge.
  always_comb begin
    lanes_packed = '0;
    for (int k = 0; k < no_of_units; k++) begin
      lanes_packed[k*element_width +: element_width] = lanes_d[k];
    end
  end

  // The outputs are registered. They are computed from the state being
  // entered, so the strobe, address and data all line up with the WRITE
  // cycle. The address and data hold their values between writes.
  always_comb begin
    we_d         = 1'b0;
    read_again_d = 1'b0;
    finish_d     = 1'b0;
    counter_d    = counter_q;
    data_d       = data_q;

    if (state_d == S_WRITE) begin
      we_d         = 1'b1;
      counter_d    = 32'(row_count_q);
      data_d       = lanes_packed;
      read_again_d = (row_count_q != LAST_ROW);
    end

    if (state_d == S_DONE) begin
      finish_d = 1'b1;
    end
  end

  // State and output registers. Reset overrides an in-flight pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      elem_count_q <= '0;
      lane_idx_q   <= '0;
      row_count_q  <= '0;
      for (int k = 0; k < no_of_units; k++) begin
        lanes_q[k] <= '0;
      end
      we_q         <= 1'b0;
      counter_q    <= '0;
      data_q       <= '0;
      read_again_q <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_count_q <= elem_count_d;
      lane_idx_q   <= lane_idx_d;
      row_count_q  <= row_count_d;
      for (int k = 0; k < no_of_units; k++) begin
        lanes_q[k] <= lanes_d[k];
      end
      we_q         <= we_d;
      counter_q    <= counter_d;
      data_q       <= data_d;
      read_again_q <= read_again_d;
      finish_q     <= finish_d;
    end
  end

endmodule

// File: tb/tb_result_writeback_packer.sv
// ---------------------------------------------------------------------------
// tb_result_writeback_packer
//
// Purpose:
//   Bench for result_writeback_packer. One instance uses the default
//   19-element vector and a second instance uses a 16-element vector, which
//   exercises the full zero row. A row-level model is built from the element
//   sequence each pass intends to deliver. The writes, read_again and finish
//   pulses are compared against that model on every cycle.
// ---------------------------------------------------------------------------
module tb_result_writeback_packer;

  localparam int U  = 8;
  localparam int EW = 32;
  localparam int DW = U * EW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          startA, startB, validA, validB;
  logic          readyA, readyB;
  logic [EW-1:0] dataInA, dataInB;
  logic          weA, weB, raA, raB, busyA, busyB, finA, finB;
  logic [31:0]   cntA, cntB;
  logic [DW-1:0] rowA, rowB;

  result_writeback_packer #(
    .no_of_units(U), .element_width(EW), .number_of_equations_per_cluster(19)
  ) dutA (
    .clk(clk), .reset(reset), .start(startA), .elem_valid(validA),
    .elem_ready(readyA), .elem_data(dataInA), .result_mem_we(weA),
    .result_mem_counter(cntA), .result_mem_data(rowA), .read_again(raA),
    .busy(busyA), .finish(finA)
  );

  result_writeback_packer #(
    .no_of_units(U), .element_width(EW), .number_of_equations_per_cluster(16)
  ) dutB (
    .clk(clk), .reset(reset), .start(startB), .elem_valid(validB),
    .elem_ready(readyB), .elem_data(dataInB), .result_mem_we(weB),
    .result_mem_counter(cntB), .result_mem_data(rowB), .read_again(raB),
    .busy(busyB), .finish(finB)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    bit            ra;
    bit            last;
  } wr_t;

  wr_t qA[$];
  wr_t qB[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit modelOn = 1'b0;
  bit finNextA = 1'b0, finNextB = 1'b0;
  bit finSeenA = 1'b0, finSeenB = 1'b0;
  int finCountA = 0, finCountB = 0, wrCountB = 0;
  int weCycA [3];
  int finCycA = 0;
  int acc8Cyc = 0, acc19Cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: elements 1..n, padded with zeros to whole rows of U lanes.
  task automatic buildExpected(input int sel, input int n);
    int pad;
    int rows;
    wr_t e;
    pad  = U - (n % U);
    rows = (n + pad) / U;
    for (int r = 0; r < rows; r++) begin
      e.addr = r;
      e.data = '0;
      for (int k = 0; k < U; k++) begin
        if (r * U + k < n) e.data[k*EW +: EW] = EW'(r * U + k + 1);
      end
      e.ra   = (r < rows - 1);
      e.last = (r == rows - 1);
      if (sel == 0) qA.push_back(e);
      else qB.push_back(e);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model queues.
  always @(negedge clk) begin
    wr_t e;
    if (modelOn) begin
      checkOutput("finishA_pulse", DW'(finA), DW'(finNextA));
      finNextA = 1'b0;
      if (finA) begin finSeenA = 1'b1; finCountA++; finCycA = cyc; end
      if (weA) begin
        if (qA.size() == 0) checkOutput("weA_unexpected", DW'(1), DW'(0));
        else begin
          e = qA.pop_front();
          checkOutput("addrA", DW'(cntA), DW'(e.addr));
          checkOutput("rowA", rowA, e.data);
          checkOutput("read_againA", DW'(raA), DW'(e.ra));
          checkOutput("readyA_in_write", DW'(readyA), DW'(0));
          checkOutput("busyA_in_write", DW'(busyA), DW'(1));
          finNextA = e.last;
          if (e.addr < 3) weCycA[e.addr] = cyc;
        end
      end else checkOutput("read_againA_idle", DW'(raA), DW'(0));

      checkOutput("finishB_pulse", DW'(finB), DW'(finNextB));
      finNextB = 1'b0;
      if (finB) begin finSeenB = 1'b1; finCountB++; end
      if (weB) begin
        wrCountB++;
        if (qB.size() == 0) checkOutput("weB_unexpected", DW'(1), DW'(0));
        else begin
          e = qB.pop_front();
          checkOutput("addrB", DW'(cntB), DW'(e.addr));
          checkOutput("rowB", rowB, e.data);
          checkOutput("read_againB", DW'(raB), DW'(e.ra));
          checkOutput("readyB_in_write", DW'(readyB), DW'(0));
          finNextB = e.last;
        end
      end else checkOutput("read_againB_idle", DW'(raB), DW'(0));
    end
  end

  // Start a pass and deliver elements 1..stopAfter. Optional throttling
  // (valid 1,0,1,0) and stray start pulses while busy.
  task automatic applyStimulus(input int sel, input int n, input bit throttle,
                               input bit startNoise, input int stopAfter);
    int idx;
    int guard;
    bit acc;
    bit phase;
    bit rowDone;
    bit v;
    bit s;
    buildExpected(sel, n);
    if (sel == 0) finSeenA = 1'b0; else finSeenB = 1'b0;
    @(posedge clk); #1;
    if (sel == 0) startA = 1'b1; else startB = 1'b1;
    @(posedge clk); #1;
    idx = 0; guard = 0; phase = 1'b1; rowDone = 1'b0;
    while (idx < stopAfter && guard < 500) begin
      v = throttle ? phase : 1'b1;
      s = startNoise && (idx == 3 || rowDone);
      if (sel == 0) begin
        validA = v; startA = s; dataInA = v ? EW'(idx + 1) : 32'hDEADBEEF;
      end else begin
        validB = v; startB = s; dataInB = v ? EW'(idx + 1) : 32'hDEADBEEF;
      end
      @(negedge clk);
      acc = (sel == 0) ? (validA && readyA) : (validB && readyB);
      @(posedge clk); #1;
      rowDone = 1'b0;
      if (acc) begin
        if (sel == 0 && idx == 7) acc8Cyc = cyc;
        if (sel == 0 && idx == n - 1) acc19Cyc = cyc;
        idx++;
        rowDone = (idx % U == 0);
      end
      phase = !phase;
      guard++;
    end
    validA = 1'b0; validB = 1'b0; startA = 1'b0; startB = 1'b0;
    if (idx < stopAfter) checkOutput("handshake_timeout", DW'(idx), DW'(stopAfter));
  endtask

  task automatic waitDone(input int sel);
    bit fs;
    fs = 1'b0;
    for (int i = 0; i < 60; i++) begin
      fs = (sel == 0) ? finSeenA : finSeenB;
      if (fs) break;
      @(posedge clk);
    end
    checkOutput("finish_seen", DW'(fs), DW'(1));
    @(posedge clk); #1;
    if (sel == 0) begin
      checkOutput("busyA_after_done", DW'(busyA), DW'(0));
      checkOutput("queueA_drained", DW'(qA.size()), DW'(0));
    end else begin
      checkOutput("busyB_after_done", DW'(busyB), DW'(0));
      checkOutput("queueB_drained", DW'(qB.size()), DW'(0));
    end
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_we"}, DW'(weA), DW'(0));
    checkOutput({tag, "_read_again"}, DW'(raA), DW'(0));
    checkOutput({tag, "_finish"}, DW'(finA), DW'(0));
    checkOutput({tag, "_counter"}, DW'(cntA), DW'(0));
    checkOutput({tag, "_data"}, rowA, DW'(0));
    checkOutput({tag, "_busy"}, DW'(busyA), DW'(0));
    checkOutput({tag, "_ready"}, DW'(readyA), DW'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] row2Lit;
    row2Lit = 256'h00000013_00000012_00000011;

    reset = 1'b0;
    startA = 1'b0; startB = 1'b0; validA = 1'b0; validB = 1'b0;
    dataInA = '0; dataInB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetA("resetA");
    checkOutput("resetB_we", DW'(weB), DW'(0));
    checkOutput("resetB_busy", DW'(busyB), DW'(0));
    checkOutput("resetB_data", rowB, DW'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    modelOn = 1'b1;

    $display("[TB] T1/T3 back-to-back 19 elements");
    applyStimulus(0, 19, 1'b0, 1'b0, 19);
    waitDone(0);
    checkOutput("T1_row2_literal", rowA, row2Lit);
    checkOutput("T1_addr_hold", DW'(cntA), DW'(2));
    checkOutput("T1_finish_count", DW'(finCountA), DW'(1));
    checkOutput("T3_we_row0_latency", DW'(weCycA[0]), DW'(acc8Cyc));
    checkOutput("T3_we_row2_latency", DW'(weCycA[2]), DW'(acc19Cyc + 1));
    checkOutput("T3_finish_latency", DW'(finCycA), DW'(acc19Cyc + 2));

    $display("[TB] T2 throttled source");
    applyStimulus(0, 19, 1'b1, 1'b0, 19);
    waitDone(0);
    checkOutput("T2_finish_count", DW'(finCountA), DW'(2));

    $display("[TB] T6 start while busy");
    applyStimulus(0, 19, 1'b0, 1'b1, 19);
    waitDone(0);
    checkOutput("T6_finish_count", DW'(finCountA), DW'(3));

    $display("[TB] T5 reset mid-pass");
    applyStimulus(0, 19, 1'b0, 1'b0, 10);
    modelOn = 1'b0;
    qA.delete();
    finNextA = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkResetA("T5_after_reset");
    @(posedge clk); #1;
    modelOn = 1'b1;
    applyStimulus(0, 19, 1'b0, 1'b0, 19);
    waitDone(0);
    checkOutput("T5_row2_literal", rowA, row2Lit);
    checkOutput("T5_finish_count", DW'(finCountA), DW'(4));

    $display("[TB] T4 N=16 full zero row");
    applyStimulus(1, 16, 1'b0, 1'b0, 16);
    waitDone(1);
    checkOutput("T4_row2_zero", rowB, DW'(0));
    checkOutput("T4_addr_hold", DW'(cntB), DW'(2));
    checkOutput("T4_write_count", DW'(wrCountB), DW'(3));
    checkOutput("T4_finish_count", DW'(finCountB), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
